// File: rtl/alu_result_collector.sv
// Result collector: picks the single active ALU unit's result each cycle, tags it,
// and queues it in a show-ahead FIFO drained by a valid/ready handshake.
module alu_result_collector #(
    parameter int ARITH_WIDTH = 32,
    parameter int LOGIC_WIDTH = 16,
    parameter int CMP_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 16,
    parameter int RES_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [ARITH_WIDTH-1:0]        Arith_OUT,
    input  logic                          Carry_OUT,
    input  logic [LOGIC_WIDTH-1:0]        Logic_OUT,
    input  logic [CMP_WIDTH-1:0]          CMP_OUT,
    input  logic [SHIFT_WIDTH-1:0]        Shift_OUT,
    input  logic                          Arith_Flag,
    input  logic                          Logic_Flag,
    input  logic                          CMP_Flag,
    input  logic                          Shift_Flag,
    input  logic                          CLR_ERR,
    input  logic                          RES_READY,
    output logic                          RES_VALID,
    output logic [RES_WIDTH-1:0]          RES_DATA,
    output logic [1:0]                    RES_UNIT,
    output logic                          RES_CARRY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVF_ERR,
    output logic                          MULTI_ERR
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [RES_WIDTH-1:0] data;
        logic [1:0]           unit;
        logic                 carry;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             push_entry;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               any_flag, multi_flag, push_req;
    logic               full, pop, push_ok, ovf_evt;

    assign any_flag   = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
    assign multi_flag = (Arith_Flag & Logic_Flag) | (Arith_Flag & CMP_Flag) |
                        (Arith_Flag & Shift_Flag) | (Logic_Flag & CMP_Flag) |
                        (Logic_Flag & Shift_Flag) | (CMP_Flag & Shift_Flag);
    assign push_req   = any_flag & ~multi_flag;

    // Priority order only matters when multi_flag is set, and then nothing is pushed.
    always_comb begin
        push_entry = '0;
        if (Arith_Flag) begin
            push_entry.data  = RES_WIDTH'(Arith_OUT);
            push_entry.unit  = 2'd0;
            push_entry.carry = Carry_OUT;
        end else if (Logic_Flag) begin
            push_entry.data  = RES_WIDTH'(Logic_OUT);
            push_entry.unit  = 2'd1;
        end else if (CMP_Flag) begin
            push_entry.data  = RES_WIDTH'(CMP_OUT);
            push_entry.unit  = 2'd2;
        end else if (Shift_Flag) begin
            push_entry.data  = RES_WIDTH'(Shift_OUT);
            push_entry.unit  = 2'd3;
        end
    end

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = (count != '0) & RES_READY;
    assign push_ok = push_req & (~full | pop);
    assign ovf_evt = push_req & full & ~pop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            OVF_ERR   <= 1'b0;
            MULTI_ERR <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count + CNT_W'(push_ok) - CNT_W'(pop);
            OVF_ERR   <= ovf_evt | (OVF_ERR & ~CLR_ERR);
            MULTI_ERR <= multi_flag | (MULTI_ERR & ~CLR_ERR);
        end
    end

    assign RES_VALID  = (count != '0);
    assign FIFO_COUNT = count;
    assign RES_DATA   = mem[rd_ptr].data;
    assign RES_UNIT   = mem[rd_ptr].unit;
    assign RES_CARRY  = mem[rd_ptr].carry;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: hand tables and sequences plus random traffic,
// all checked against a queue-based reference model.
module tb_alu_result_collector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] arith;
    logic        cy;
    logic [15:0] lo, cmp, sh;
    logic        af, lf, cf, sf;
    logic        clr, rdy;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_unit;
    logic        res_carry;
    logic [2:0]  fifo_count;
    logic        ovf_err, multi_err;

    int checks = 0;
    int errors = 0;

    alu_result_collector dut (
        .CLK(clk), .RST(rst),
        .Arith_OUT(arith), .Carry_OUT(cy), .Logic_OUT(lo), .CMP_OUT(cmp), .Shift_OUT(sh),
        .Arith_Flag(af), .Logic_Flag(lf), .CMP_Flag(cf), .Shift_Flag(sf),
        .CLR_ERR(clr), .RES_READY(rdy),
        .RES_VALID(res_valid), .RES_DATA(res_data), .RES_UNIT(res_unit),
        .RES_CARRY(res_carry), .FIFO_COUNT(fifo_count),
        .OVF_ERR(ovf_err), .MULTI_ERR(multi_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  u;
        logic        c;
    } ent_t;

    ent_t q[$];
    bit   m_ovf, m_multi, m_clean;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input bit a, l, c, s, input logic [31:0] v, input bit carry,
                         input bit ready, input bit cl);
        af = a; lf = l; cf = c; sf = s;
        arith = v; lo = v[15:0]; cmp = v[15:0]; sh = v[15:0];
        cy = carry; rdy = ready; clr = cl; rst = 1'b0;
    endtask

    // Model update from pre-edge state and inputs, then one edge, then compare.
    task automatic cycle();
        int   nf;
        bit   pop, ovfev;
        ent_t e;
        nf  = int'(af) + int'(lf) + int'(cf) + int'(sf);
        pop = (q.size() > 0) && rdy;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_multi = 0; m_clean = 1;
        end else begin
            ovfev = (nf == 1) && (q.size() == DEPTH) && !pop;
            if (pop) e = q.pop_front();
            if (nf == 1 && !ovfev) begin
                e.c = 1'b0;
                if (af)      begin e.d = arith;        e.u = 2'd0; e.c = cy; end
                else if (lf) begin e.d = {16'h0, lo};  e.u = 2'd1; end
                else if (cf) begin e.d = {16'h0, cmp}; e.u = 2'd2; end
                else         begin e.d = {16'h0, sh};  e.u = 2'd3; end
                q.push_back(e);
                m_clean = 0;
            end
            m_ovf   = ovfev    ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_multi = (nf > 1) ? 1'b1 : (clr ? 1'b0 : m_multi);
        end
        @(posedge clk); #1;
        chk("valid", res_valid, q.size() != 0);
        chk("count", fifo_count, q.size());
        chk("ovf", ovf_err, m_ovf);
        chk("multi", multi_err, m_multi);
        if (q.size() != 0) begin
            chk("data", res_data, q[0].d);
            chk("unit", res_unit, q[0].u);
            chk("carry", res_carry, q[0].c);
        end else if (m_clean) begin
            chk("rst_data", res_data, 0);
            chk("rst_unit", res_unit, 0);
            chk("rst_carry", res_carry, 0);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit a, l, c, s;
        logic [31:0] v;
        bit carry, ready, cl;
        int exp_count;
        bit chk_head;
        logic [31:0] exp_data;
        logic [1:0]  exp_unit;
        bit exp_carry, exp_ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        //        a  l  c  s  value        cy rdy clr cnt head data        unit cy ovf
        tbl[0] = '{0, 1, 0, 0, 32'h2,       0, 0, 0, 1, 1, 32'h2,       2'd1, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 32'h2,       0, 0, 0, 2, 1, 32'h2,       2'd1, 0, 0};
        tbl[2] = '{0, 0, 0, 1, 32'hC,       0, 0, 0, 3, 1, 32'h2,       2'd1, 0, 0};
        tbl[3] = '{1, 0, 0, 0, 32'h1FFFE,   1, 0, 0, 4, 1, 32'h2,       2'd1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 32'h6,       0, 0, 0, 4, 1, 32'h2,       2'd1, 0, 1};
        tbl[5] = '{0, 0, 0, 0, 32'h0,       0, 1, 0, 3, 1, 32'h2,       2'd2, 0, 1};
        tbl[6] = '{0, 0, 0, 0, 32'h0,       0, 1, 0, 2, 1, 32'hC,       2'd3, 0, 1};
        tbl[7] = '{0, 0, 0, 0, 32'h0,       0, 1, 0, 1, 1, 32'h1FFFE,   2'd0, 1, 1};
        tbl[8] = '{0, 0, 0, 0, 32'h0,       0, 1, 0, 0, 0, 32'h0,       2'd0, 0, 1};
        tbl[9] = '{0, 0, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0,       2'd0, 0, 0};

        do_reset();

        // Single arith result with one-cycle latency, consumed next cycle.
        drive(1, 0, 0, 0, 32'd9, 0, 1, 0); cycle();
        chk("t1_valid", res_valid, 1);
        chk("t1_data", res_data, 9);
        drive(0, 0, 0, 0, 0, 0, 1, 0); cycle();
        chk("t1_empty", fifo_count, 0);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].a, tbl[i].l, tbl[i].c, tbl[i].s, tbl[i].v, tbl[i].carry,
                  tbl[i].ready, tbl[i].cl);
            cycle();
            chk("tbl_count", fifo_count, tbl[i].exp_count);
            chk("tbl_valid", res_valid, tbl[i].exp_count != 0);
            chk("tbl_ovf", ovf_err, tbl[i].exp_ovf);
            if (tbl[i].chk_head) begin
                chk("tbl_data", res_data, tbl[i].exp_data);
                chk("tbl_unit", res_unit, tbl[i].exp_unit);
                chk("tbl_carry", res_carry, tbl[i].exp_carry);
            end
        end

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 32'h10 + i, 0, 0, 0); cycle();
        end
        drive(0, 1, 0, 0, 32'hFFFD, 0, 1, 0); cycle();
        chk("full_pp_count", fifo_count, 4);
        chk("full_pp_ovf", ovf_err, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0); cycle();
        end
        chk("full_pp_last", res_data, 32'hFFFD);
        chk("full_pp_lastcnt", fifo_count, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0); cycle();

        // Multi-unit cycle, then clear.
        drive(1, 0, 0, 1, 32'h55, 1, 0, 0); cycle();
        chk("multi_set", multi_err, 1);
        chk("multi_count", fifo_count, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        chk("multi_clr", multi_err, 0);
        // Error event coincident with clear keeps the bit set.
        drive(0, 1, 1, 0, 32'h7, 0, 0, 1); cycle();
        chk("multi_win", multi_err, 1);

        // Mid-stream reset with a flag high.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 32'h40 + i, 0, 0, 0); cycle();
        end
        drive(0, 1, 0, 0, 32'h99, 0, 0, 0);
        rst = 1'b1;
        cycle();
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_dat", res_data, 0);
        chk("rst_err", {ovf_err, multi_err}, 0);

        // Idle with toggling ready.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, $urandom, 1'(i), 1'(i), 0); cycle();
        end
        chk("idle_count", fifo_count, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            drive(0, 0, 0, 0, $urandom, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  $urandom_range(0, 15) == 0);
            if (r < 6) begin
                case ($urandom_range(0, 3))
                    0: af = 1;
                    1: lf = 1;
                    2: cf = 1;
                    default: sf = 1;
                endcase
            end else if (r == 6) begin
                {af, lf, cf, sf} = 4'($urandom);
            end
            if (i > 200) rdy = 1'($urandom);
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
